// File: rtl/vector_unpack_rx_pkg.sv
// vector_pkg: shared types and widths for the vector unpack receiver.
//   state_t  : receiver FSM states (IDLE, DATA, STOP)
//   WORD_W   : serial data word width (bits per frame payload)
//   NIBBLE_W : width of each decoded operand
package vector_pkg;

  localparam int WORD_W   = 8;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STOP
  } state_t;

endpackage

// File: rtl/vector_unpack_rx_if.sv
// vector_unpack_rx_if: serial line input plus decoded result bus of the
// vector unpack receiver.
//   rx_in, bit_en            : serial line and its sample strobe
//   a, b, a_and_b            : decoded operands and their bitwise AND
//   a_reduction_or,
//   b_reduction_or           : OR-reductions of the decoded operands
//   valid, frame_err, busy   : load pulse, bad-stop pulse, frame in progress
// master drives the serial line; slave is the receiver.
interface vector_unpack_rx_if;
  import vector_pkg::*;

  logic                rx_in;
  logic                bit_en;
  logic [NIBBLE_W-1:0] a;
  logic [NIBBLE_W-1:0] b;
  logic [NIBBLE_W-1:0] a_and_b;
  logic                a_reduction_or;
  logic                b_reduction_or;
  logic                valid;
  logic                frame_err;
  logic                busy;

  modport master (
    output rx_in, bit_en,
    input  a, b, a_and_b, a_reduction_or, b_reduction_or,
           valid, frame_err, busy
  );

  modport slave (
    input  rx_in, bit_en,
    output a, b, a_and_b, a_reduction_or, b_reduction_or,
           valid, frame_err, busy
  );

endinterface

// File: rtl/vector_unpack_rx_decode.sv
// vector_decode: purely combinational decode of a received word.
// The frame carries {~a, ~b}, so both nibbles are inverted back here.
//   w              : received word
//   a, b           : decoded operands (upper / lower nibble, inverted)
//   a_and_b        : bitwise AND of a and b
//   a_reduction_or : OR of the bits of a
//   b_reduction_or : OR of the bits of b
module vector_decode
  import vector_pkg::*;
(
  input  logic [WORD_W-1:0]   w,
  output logic [NIBBLE_W-1:0] a,
  output logic [NIBBLE_W-1:0] b,
  output logic [NIBBLE_W-1:0] a_and_b,
  output logic                a_reduction_or,
  output logic                b_reduction_or
);

  assign a              = ~w[WORD_W-1 -: NIBBLE_W];
  assign b              = ~w[NIBBLE_W-1:0];
  assign a_and_b        = a & b;
  assign a_reduction_or = |a;
  assign b_reduction_or = |b;

endmodule

// File: rtl/vector_unpack_rx.sv
// vector_unpack_rx: serial receiver for frames of 1 start bit (0),
// WORD_W data bits and 1 stop bit (1), one bit per bit_en sample.
// A good stop bit loads the decoded operands into registered outputs and
// pulses valid the cycle after; a bad stop bit pulses frame_err instead
// and leaves the outputs untouched.
//   MSB_FIRST : 1 = data bits arrive MSB first, 0 = LSB first
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   rx_if     : slave side of vector_unpack_rx_if (line in, results out)
module vector_unpack_rx
  import vector_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  vector_unpack_rx_if.slave  rx_if
);

  localparam int CNT_W = $clog2(WORD_W);

  state_t              state;
  state_t              state_next;
  logic [CNT_W-1:0]    bit_cnt;
  logic [WORD_W-1:0]   shift_w;

  logic                shift_en;
  logic                clr_cnt;
  logic                load;
  logic                bad_stop;

  logic [NIBBLE_W-1:0] dec_a;
  logic [NIBBLE_W-1:0] dec_b;
  logic [NIBBLE_W-1:0] dec_and;
  logic                dec_a_or;
  logic                dec_b_or;

  logic [NIBBLE_W-1:0] a_q;
  logic [NIBBLE_W-1:0] b_q;
  logic [NIBBLE_W-1:0] and_q;
  logic                a_or_q;
  logic                b_or_q;
  logic                valid_q;
  logic                frame_err_q;

  vector_decode u_decode (
    .w              (shift_w),
    .a              (dec_a),
    .b              (dec_b),
    .a_and_b        (dec_and),
    .a_reduction_or (dec_a_or),
    .b_reduction_or (dec_b_or)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath controls; nothing advances without bit_en.
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    clr_cnt    = 1'b0;
    load       = 1'b0;
    bad_stop   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_if.bit_en && !rx_if.rx_in) begin
          state_next = DATA;
          clr_cnt    = 1'b1;
        end
      end
      DATA: begin
        if (rx_if.bit_en) begin
          shift_en = 1'b1;
          if (bit_cnt == CNT_W'(WORD_W - 1)) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (rx_if.bit_en) begin
          state_next = IDLE;
          if (rx_if.rx_in) begin
            load = 1'b1;
          end else begin
            bad_stop = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bit counter and shift register. Shifting toward the MSB or LSB end
  // makes the first-received bit land at w[7] or w[0] respectively.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shift_w <= '0;
    end else begin
      if (clr_cnt) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (shift_en) begin
        if (MSB_FIRST) begin
          shift_w <= {shift_w[WORD_W-2:0], rx_if.rx_in};
        end else begin
          shift_w <= {rx_if.rx_in, shift_w[WORD_W-1:1]};
        end
      end
    end
  end

  // Registered results: data change only on a good stop; the pulses are
  // derived from mutually exclusive stop-bit outcomes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      and_q       <= '0;
      a_or_q      <= 1'b0;
      b_or_q      <= 1'b0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      valid_q     <= load;
      frame_err_q <= bad_stop;
      if (load) begin
        a_q    <= dec_a;
        b_q    <= dec_b;
        and_q  <= dec_and;
        a_or_q <= dec_a_or;
        b_or_q <= dec_b_or;
      end
    end
  end

  assign rx_if.a              = a_q;
  assign rx_if.b              = b_q;
  assign rx_if.a_and_b        = and_q;
  assign rx_if.a_reduction_or = a_or_q;
  assign rx_if.b_reduction_or = b_or_q;
  assign rx_if.valid          = valid_q;
  assign rx_if.frame_err      = frame_err_q;
  assign rx_if.busy           = (state != IDLE);

endmodule

// File: tb/tb_vector_unpack_rx.sv
// tb_vector_unpack_rx: self-checking bench for vector_unpack_rx.
// Two receivers share clock and reset: one MSB-first, one LSB-first.
// Expected {a,b} pairs are queued when a frame with a good stop bit is
// driven and popped when the matching receiver pulses valid.
module tb_vector_unpack_rx;
  import vector_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  int total = 0;
  int bad = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int         vcyc0[$];
  int         vcnt0 = 0;
  int         vcnt1 = 0;
  int         ecnt0 = 0;
  int         ecnt1 = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  vector_unpack_rx_if if_msb ();
  vector_unpack_rx_if if_lsb ();

  vector_unpack_rx #(.MSB_FIRST(1'b1)) u_dut_msb (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_if (if_msb.slave)
  );

  vector_unpack_rx #(.MSB_FIRST(1'b0)) u_dut_lsb (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_if (if_lsb.slave)
  );

  task automatic checkOutput(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic checkDecode(input string tag, input logic [7:0] e,
                             input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] ab, input logic ra,
                             input logic rb);
    checkOutput({tag, ".a"}, int'(a), int'(e[7:4]));
    checkOutput({tag, ".b"}, int'(b), int'(e[3:0]));
    checkOutput({tag, ".and"}, int'(ab), int'(e[7:4] & e[3:0]));
    checkOutput({tag, ".ora"}, int'(ra), int'(|e[7:4]));
    checkOutput({tag, ".orb"}, int'(rb), int'(|e[3:0]));
  endtask

  // Scoreboard monitors, sampling on the inactive edge.
  always @(negedge clk) begin
    if (if_msb.valid || if_msb.frame_err)
      checkOutput("msb excl", int'(if_msb.valid & if_msb.frame_err), 0);
    if (if_msb.frame_err) ecnt0++;
    if (if_msb.valid) begin
      vcnt0++;
      vcyc0.push_back(cyc);
      if (exp_q0.size() == 0) begin
        checkOutput("msb unexpected valid", 1, 0);
      end else begin
        checkDecode("msb", exp_q0.pop_front(), if_msb.a, if_msb.b,
                    if_msb.a_and_b, if_msb.a_reduction_or,
                    if_msb.b_reduction_or);
      end
    end
  end

  always @(negedge clk) begin
    if (if_lsb.valid || if_lsb.frame_err)
      checkOutput("lsb excl", int'(if_lsb.valid & if_lsb.frame_err), 0);
    if (if_lsb.frame_err) ecnt1++;
    if (if_lsb.valid) begin
      vcnt1++;
      if (exp_q1.size() == 0) begin
        checkOutput("lsb unexpected valid", 1, 0);
      end else begin
        checkDecode("lsb", exp_q1.pop_front(), if_lsb.a, if_lsb.b,
                    if_lsb.a_and_b, if_lsb.a_reduction_or,
                    if_lsb.b_reduction_or);
      end
    end
  end

  task automatic driveLine(input bit sel, input logic en, input logic rx);
    if (sel) begin
      if_lsb.bit_en = en;
      if_lsb.rx_in  = rx;
    end else begin
      if_msb.bit_en = en;
      if_msb.rx_in  = rx;
    end
  endtask

  task automatic idleCycles(input bit sel, input int n);
    repeat (n) begin
      @(negedge clk);
      driveLine(sel, 1'b0, 1'b1);
    end
  endtask

  // One bit_en sample every 'stride' cycles.
  task automatic sendBit(input bit sel, input logic bit_val, input int stride);
    @(negedge clk);
    driveLine(sel, 1'b1, bit_val);
    repeat (stride - 1) begin
      @(negedge clk);
      driveLine(sel, 1'b0, 1'b1);
    end
  endtask

  task automatic applyStimulus(input bit sel, input logic [7:0] word,
                               input logic stop, input int stride);
    logic [7:0] expv;
    expv = {~word[7:4], ~word[3:0]};
    if (stop) begin
      if (sel) exp_q1.push_back(expv);
      else     exp_q0.push_back(expv);
    end
    sendBit(sel, 1'b0, stride);
    for (int i = 0; i < 8; i++) begin
      sendBit(sel, sel ? word[i] : word[7-i], stride);
    end
    sendBit(sel, stop, stride);
  endtask

  initial begin
    int v0;
    int e0;
    logic [7:0] part;

    driveLine(1'b0, 1'b0, 1'b1);
    driveLine(1'b1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);

    checkOutput("rst a", int'(if_msb.a), 0);
    checkOutput("rst b", int'(if_msb.b), 0);
    checkOutput("rst and", int'(if_msb.a_and_b), 0);
    checkOutput("rst ora", int'(if_msb.a_reduction_or), 0);
    checkOutput("rst orb", int'(if_msb.b_reduction_or), 0);
    checkOutput("rst valid", int'(if_msb.valid), 0);
    checkOutput("rst ferr", int'(if_msb.frame_err), 0);
    checkOutput("rst busy", int'(if_msb.busy), 0);

    rst_n = 1'b1;
    idleCycles(1'b0, 2);

    // First frame right after reset; valid exactly one cycle after stop.
    applyStimulus(1'b0, 8'h5C, 1'b1, 1);
    @(negedge clk);
    driveLine(1'b0, 1'b0, 1'b1);
    checkOutput("valid latency", int'(if_msb.valid), 1);
    @(negedge clk);
    checkOutput("valid width", int'(if_msb.valid), 0);
    checkOutput("count after 5C", vcnt0, 1);

    applyStimulus(1'b0, 8'hFF, 1'b1, 1);
    idleCycles(1'b0, 3);
    applyStimulus(1'b0, 8'h0F, 1'b1, 1);
    idleCycles(1'b0, 3);

    // Bad stop bit: error pulse only, outputs hold a=F, b=0.
    v0 = vcnt0;
    e0 = ecnt0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1);
    idleCycles(1'b0, 3);
    checkOutput("ferr pulses", ecnt0, e0 + 1);
    checkOutput("no valid on ferr", vcnt0, v0);
    checkOutput("hold a", int'(if_msb.a), 4'hF);
    checkOutput("hold b", int'(if_msb.b), 0);
    checkOutput("hold and", int'(if_msb.a_and_b), 0);
    checkOutput("hold ora", int'(if_msb.a_reduction_or), 1);

    // Slow strobe, back-to-back frames.
    vcyc0.delete();
    applyStimulus(1'b0, 8'h5C, 1'b1, 3);
    applyStimulus(1'b0, 8'h0F, 1'b1, 3);
    idleCycles(1'b0, 4);
    checkOutput("b2b slow count", vcyc0.size(), 2);
    checkOutput("b2b slow spacing",
                (vcyc0.size() == 2) ? vcyc0[1] - vcyc0[0] : 0, 30);

    // Continuous strobe, back-to-back frames.
    vcyc0.delete();
    applyStimulus(1'b0, 8'h0F, 1'b1, 1);
    applyStimulus(1'b0, 8'h5C, 1'b1, 1);
    idleCycles(1'b0, 4);
    checkOutput("b2b fast count", vcyc0.size(), 2);
    checkOutput("b2b fast spacing",
                (vcyc0.size() == 2) ? vcyc0[1] - vcyc0[0] : 0, 10);

    // Reset in the middle of a frame after the 4th data bit.
    v0 = vcnt0;
    e0 = ecnt0;
    part = 8'h5C;
    sendBit(1'b0, 1'b0, 1);
    for (int i = 0; i < 4; i++) sendBit(1'b0, part[7-i], 1);
    @(negedge clk);
    driveLine(1'b0, 1'b0, 1'b1);
    checkOutput("busy mid frame", int'(if_msb.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async rst a", int'(if_msb.a), 0);
    checkOutput("async rst b", int'(if_msb.b), 0);
    checkOutput("async rst and", int'(if_msb.a_and_b), 0);
    checkOutput("async rst ora", int'(if_msb.a_reduction_or), 0);
    checkOutput("async rst busy", int'(if_msb.busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idleCycles(1'b0, 20);
    checkOutput("aborted valid", vcnt0, v0);
    checkOutput("aborted ferr", ecnt0, e0);
    applyStimulus(1'b0, 8'h96, 1'b1, 1);
    idleCycles(1'b0, 3);
    checkOutput("count after 96", vcnt0, v0 + 1);

    // LSB-first receiver.
    applyStimulus(1'b1, 8'h5C, 1'b1, 1);
    idleCycles(1'b1, 3);
    checkOutput("lsb count", vcnt1, 1);
    checkOutput("lsb ferr", ecnt1, 0);

    checkOutput("msb drained", exp_q0.size(), 0);
    checkOutput("lsb drained", exp_q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
